// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared widths, arbiter state encoding and source-match helper for the writeback scheduler.
package regfile_wb_scheduler_pkg;

  localparam int unsigned RdWidth       = 5;
  localparam int unsigned RegisterWidth = 32;
  localparam int unsigned RegisterNum   = 32;

  typedef enum logic [0:0] {
    ArbPriLd  = 1'b0,
    ArbPriAlu = 1'b1
  } arb_state_e;

  // Source matches the register currently on the write port (never $0).
  function automatic logic src_hit(input logic [RdWidth-1:0] wb_rd,
                                   input logic [RdWidth-1:0] src);
    return (wb_rd == src) && (src != '0);
  endfunction

endpackage

// File: rtl/regfile_wb_scheduler_wb_scoreboard.sv
// Per-register pending-write scoreboard with rs/rt lookup; $0 never reads busy.
module wb_scoreboard
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int unsigned REG_NUM = RegisterNum
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_set_vld,
  input  logic [RdWidth-1:0] i_set_rd,
  input  logic               i_clr_vld,
  input  logic [RdWidth-1:0] i_clr_rd,
  input  logic [RdWidth-1:0] i_wb_rd,
  input  logic [RdWidth-1:0] i_rs,
  input  logic [RdWidth-1:0] i_rt,
  output logic               o_rs_pend,
  output logic               o_rt_pend,
  output logic               o_rs_hit,
  output logic               o_rt_hit
);

  logic [REG_NUM-1:0] busy_d, busy_q;

  always_comb begin
    busy_d = busy_q;
    if (i_clr_vld) begin
      busy_d[i_clr_rd] = 1'b0;
    end
    // Applied after the clear so a newer producer keeps the entry pending.
    if (i_set_vld && (i_set_rd != '0)) begin
      busy_d[i_set_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    o_rs_pend = busy_q[i_rs];
    o_rt_pend = busy_q[i_rt];
    o_rs_hit  = src_hit(i_wb_rd, i_rs);
    o_rt_hit  = src_hit(i_wb_rd, i_rt);
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates ALU/load writeback onto the register-file write port with ALU anti-starvation.
// Define REGFILE_WB_FWD_EN to add forwarding outputs and drop the write-port stall term.
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned REG_NUM      = RegisterNum
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_issue_vld,
  input  logic [RdWidth-1:0]       i_issue_rd,
  input  logic [RdWidth-1:0]       i_rs,
  input  logic [RdWidth-1:0]       i_rt,
  output logic                     o_rs_busy,
  output logic                     o_rt_busy,
  input  logic                     i_alu_vld,
  input  logic [RdWidth-1:0]       i_alu_rd,
  input  logic [RegisterWidth-1:0] i_alu_data,
  output logic                     o_alu_rdy,
  input  logic                     i_ld_vld,
  input  logic [RdWidth-1:0]       i_ld_rd,
  input  logic [RegisterWidth-1:0] i_ld_data,
  output logic                     o_ld_rdy,
`ifdef REGFILE_WB_FWD_EN
  output logic                     o_rs_fwd,
  output logic                     o_rt_fwd,
  output logic [RegisterWidth-1:0] o_fwd_data,
`endif
  output logic [RdWidth-1:0]       o_rd,
  output logic [RegisterWidth-1:0] o_rd_data
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  arb_state_e               state_q;
  logic [CntW-1:0]          starve_cnt_q;
  logic [RdWidth-1:0]       rd_q;
  logic [RegisterWidth-1:0] rd_data_q;

  logic                     alu_gnt, ld_gnt, any_gnt, alu_blocked;
  logic [RdWidth-1:0]       gnt_rd;
  logic [RegisterWidth-1:0] gnt_data;

  always_comb begin
    alu_gnt     = i_alu_vld && ((state_q == ArbPriAlu) || !i_ld_vld);
    ld_gnt      = i_ld_vld && !alu_gnt;
    any_gnt     = alu_gnt || ld_gnt;
    alu_blocked = i_alu_vld && !alu_gnt;
    gnt_rd      = alu_gnt ? i_alu_rd : i_ld_rd;
    gnt_data    = alu_gnt ? i_alu_data : i_ld_data;
  end

  assign o_alu_rdy = alu_gnt;
  assign o_ld_rdy  = ld_gnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ArbPriLd;
      starve_cnt_q <= '0;
      rd_q         <= '0;
      rd_data_q    <= '0;
    end else begin
      rd_q      <= any_gnt ? gnt_rd : '0;
      // Writes to $0 are accepted but never put data on the port.
      rd_data_q <= (any_gnt && (gnt_rd != '0)) ? gnt_data : '0;
      case (state_q)
        ArbPriLd: begin
          if (alu_gnt) begin
            starve_cnt_q <= '0;
          end else if (alu_blocked) begin
            starve_cnt_q <= starve_cnt_q + 1'b1;
            if (starve_cnt_q == CntW'(STARVE_LIMIT - 1)) begin
              state_q <= ArbPriAlu;
            end
          end
        end
        ArbPriAlu: begin
          if (alu_gnt) begin
            state_q      <= ArbPriLd;
            starve_cnt_q <= '0;
          end
        end
        default: begin
          state_q      <= ArbPriLd;
          starve_cnt_q <= '0;
        end
      endcase
    end
  end

  assign o_rd      = rd_q;
  assign o_rd_data = rd_data_q;

  logic rs_pend, rt_pend, rs_hit, rt_hit;

  wb_scoreboard #(
    .REG_NUM (REG_NUM)
  ) u_scoreboard (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_set_vld (i_issue_vld),
    .i_set_rd  (i_issue_rd),
    .i_clr_vld (any_gnt),
    .i_clr_rd  (gnt_rd),
    .i_wb_rd   (rd_q),
    .i_rs      (i_rs),
    .i_rt      (i_rt),
    .o_rs_pend (rs_pend),
    .o_rt_pend (rt_pend),
    .o_rs_hit  (rs_hit),
    .o_rt_hit  (rt_hit)
  );

`ifdef REGFILE_WB_FWD_EN
  assign o_rs_fwd   = rs_hit;
  assign o_rt_fwd   = rt_hit;
  assign o_fwd_data = rd_data_q;
  assign o_rs_busy  = rs_pend;
  assign o_rt_busy  = rt_pend;
`else
  // The write-port term covers the cycle before the register file captures the value.
  assign o_rs_busy  = rs_pend | rs_hit;
  assign o_rt_busy  = rt_pend | rt_hit;
`endif

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: arbitration, starvation, scoreboard and async reset.
module tb_regfile_wb_scheduler;

  logic        clk;
  logic        rst_n;
  logic        issue_vld;
  logic [4:0]  issue_rd, rs, rt;
  logic        rs_busy, rt_busy;
  logic        alu_vld, alu_rdy, ld_vld, ld_rdy;
  logic [4:0]  alu_rd, ld_rd, rd;
  logic [31:0] alu_data, ld_data, rd_data;
`ifdef REGFILE_WB_FWD_EN
  logic        rs_fwd, rt_fwd;
  logic [31:0] fwd_data;
`endif

  int n_vec = 0;
  int n_err = 0;

  regfile_wb_scheduler #(
    .STARVE_LIMIT (4),
    .REG_NUM      (32)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_issue_vld (issue_vld),
    .i_issue_rd  (issue_rd),
    .i_rs        (rs),
    .i_rt        (rt),
    .o_rs_busy   (rs_busy),
    .o_rt_busy   (rt_busy),
    .i_alu_vld   (alu_vld),
    .i_alu_rd    (alu_rd),
    .i_alu_data  (alu_data),
    .o_alu_rdy   (alu_rdy),
    .i_ld_vld    (ld_vld),
    .i_ld_rd     (ld_rd),
    .i_ld_data   (ld_data),
    .o_ld_rdy    (ld_rdy),
`ifdef REGFILE_WB_FWD_EN
    .o_rs_fwd    (rs_fwd),
    .o_rt_fwd    (rt_fwd),
    .o_fwd_data  (fwd_data),
`endif
    .o_rd        (rd),
    .o_rd_data   (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; checks follow 1ns later, so registered
  // outputs reflect the rising edge before this step.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; issue_vld = 1'b0; issue_rd = '0; rs = '0; rt = '0;
    alu_vld = 1'b0; alu_rd = '0; alu_data = '0;
    ld_vld = 1'b0; ld_rd = '0; ld_data = '0;
    #12;
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_data", rd_data, 32'd0);
    chk("rst_alu_rdy", 32'(alu_rdy), 32'd0);
    chk("rst_ld_rdy", 32'(ld_rdy), 32'd0);
    step(); rst_n = 1'b1;

    // 1: ALU alone
    step(); alu_vld = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234; #1;
    chk("t1_alu_rdy", 32'(alu_rdy), 32'd1);
    chk("t1_ld_rdy", 32'(ld_rdy), 32'd0);
    chk("t1_rd_pre", 32'(rd), 32'd0);
    step(); alu_vld = 1'b0; #1;
    chk("t1_rd", 32'(rd), 32'd5);
    chk("t1_data", rd_data, 32'h1234);
    step(); #1;
    chk("t1_rd_idle", 32'(rd), 32'd0);
    chk("t1_data_idle", rd_data, 32'd0);

    // 2: both valid, load wins first
    step();
    ld_vld = 1'b1; ld_rd = 5'd3; ld_data = 32'hAAAA;
    alu_vld = 1'b1; alu_rd = 5'd4; alu_data = 32'hBBBB; #1;
    chk("t2_ld_rdy", 32'(ld_rdy), 32'd1);
    chk("t2_alu_blk", 32'(alu_rdy), 32'd0);
    step(); ld_vld = 1'b0; #1;
    chk("t2_rd3", 32'(rd), 32'd3);
    chk("t2_data3", rd_data, 32'hAAAA);
    chk("t2_alu_rdy", 32'(alu_rdy), 32'd1);
    step(); alu_vld = 1'b0; #1;
    chk("t2_rd4", 32'(rd), 32'd4);
    chk("t2_data4", rd_data, 32'hBBBB);
    step(); #1;
    chk("t2_rd0", 32'(rd), 32'd0);

    // 3: ALU starved by continuous loads for exactly 4 cycles
    step();
    ld_vld = 1'b1; ld_rd = 5'd1; ld_data = 32'h11;
    alu_vld = 1'b1; alu_rd = 5'd2; alu_data = 32'h22; #1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_alu_blocked", 32'(alu_rdy), 32'd0);
      chk("t3_ld_win", 32'(ld_rdy), 32'd1);
      step(); #1;
    end
    chk("t3_alu_forced", 32'(alu_rdy), 32'd1);
    chk("t3_ld_held", 32'(ld_rdy), 32'd0);
    step(); alu_vld = 1'b0; #1;
    chk("t3_rd_alu", 32'(rd), 32'd2);
    chk("t3_ld_again", 32'(ld_rdy), 32'd1);
    step(); alu_vld = 1'b1; #1;
    chk("t3_pri_ld_back", 32'(ld_rdy), 32'd1);
    chk("t3_alu_blk_again", 32'(alu_rdy), 32'd0);
    step(); ld_vld = 1'b0; #1;
    chk("t3_rd_ld", 32'(rd), 32'd1);
    chk("t3_alu_free", 32'(alu_rdy), 32'd1);
    step(); alu_vld = 1'b0;
    step(); #1;
    chk("t3_rd0", 32'(rd), 32'd0);

    // 4: scoreboard set/clear around a write to 7
    step(); issue_vld = 1'b1; issue_rd = 5'd7; rs = 5'd7; rt = 5'd3; #1;
    chk("t4_busy_pre", 32'(rs_busy), 32'd0);
    step(); issue_vld = 1'b0; alu_vld = 1'b1; alu_rd = 5'd7; alu_data = 32'h77; #1;
    chk("t4_busy_set", 32'(rs_busy), 32'd1);
    chk("t4_rt_free", 32'(rt_busy), 32'd0);
    step(); alu_vld = 1'b0; #1;
    chk("t4_rd7", 32'(rd), 32'd7);
`ifdef REGFILE_WB_FWD_EN
    chk("t4_busy_wb", 32'(rs_busy), 32'd0);
    chk("t4_fwd", 32'(rs_fwd), 32'd1);
    chk("t4_fwd_data", fwd_data, 32'h77);
`else
    chk("t4_busy_wb", 32'(rs_busy), 32'd1);
`endif
    step(); #1;
    chk("t4_busy_clr", 32'(rs_busy), 32'd0);

    // 5: set beats clear on the same register; $0 never busy
    step();
    issue_vld = 1'b1; issue_rd = 5'd9; rs = 5'd9; rt = 5'd9;
    alu_vld = 1'b1; alu_rd = 5'd9; alu_data = 32'h99; #1;
    chk("t5_alu_rdy", 32'(alu_rdy), 32'd1);
    step(); issue_vld = 1'b0; alu_vld = 1'b0; #1;
    chk("t5_rd9", 32'(rd), 32'd9);
    chk("t5_rs_busy", 32'(rs_busy), 32'd1);
    step(); #1;
    chk("t5_rd0", 32'(rd), 32'd0);
    chk("t5_busy_kept", 32'(rt_busy), 32'd1);
    step(); alu_vld = 1'b1; alu_rd = 5'd9; alu_data = 32'h9A;
    step(); alu_vld = 1'b0;
    step(); #1;
    chk("t5_busy_clr", 32'(rt_busy), 32'd0);
    step(); issue_vld = 1'b1; issue_rd = 5'd0; rs = 5'd0; rt = 5'd0;
    alu_vld = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
    step(); issue_vld = 1'b0; alu_vld = 1'b0; #1;
    chk("t5_rs0_busy", 32'(rs_busy), 32'd0);
    chk("t5_rd0_data", rd_data, 32'd0);

    // 6: asynchronous reset while o_rd=6, with register 8 pending
    step(); issue_vld = 1'b1; issue_rd = 5'd8; rs = 5'd8; rt = 5'd6;
    step(); issue_vld = 1'b0; alu_vld = 1'b1; alu_rd = 5'd6; alu_data = 32'h66;
    step(); alu_vld = 1'b0; #1;
    chk("t6_rd6", 32'(rd), 32'd6);
    chk("t6_rs_busy", 32'(rs_busy), 32'd1);
    #1 rst_n = 1'b0; #1;
    chk("t6_rst_rd", 32'(rd), 32'd0);
    chk("t6_rst_data", rd_data, 32'd0);
    chk("t6_rst_rs", 32'(rs_busy), 32'd0);
    chk("t6_rst_rt", 32'(rt_busy), 32'd0);
    step(); rst_n = 1'b1;
    step();
    ld_vld = 1'b1; ld_rd = 5'd10; ld_data = 32'hA0;
    alu_vld = 1'b1; alu_rd = 5'd11; alu_data = 32'hB0; #1;
    chk("t6_pri_ld", 32'(ld_rdy), 32'd1);
    chk("t6_alu_wait", 32'(alu_rdy), 32'd0);
    step(); ld_vld = 1'b0; #1;
    chk("t6_rd10", 32'(rd), 32'd10);
    step(); alu_vld = 1'b0; #1;
    chk("t6_rd11", 32'(rd), 32'd11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
